// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin scheduler that time-shares one external
// W-bit combinational adder among N_REQ requesters. Operands are granted over
// valid/ready, registered onto the adder, the sum is captured one cycle later
// and returned with the owner's ID over a valid/ready response channel.
module adder_share_arb #(
    parameter int N_REQ = 4,
    parameter int W     = 32,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [N_REQ*W-1:0] i_req_a,
    input  logic [N_REQ*W-1:0] i_req_b,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic [W-1:0]       o_add_a,
    output logic [W-1:0]       o_add_b,
    input  logic [W-1:0]       i_add_sum,
    output logic               o_rsp_valid,
    output logic [IDW-1:0]     o_rsp_id,
    output logic [W-1:0]       o_rsp_sum,
    input  logic               i_rsp_ready,
    output logic [15:0]        o_op_cnt
);

    // IDLE: waiting for a request; EXEC: adder busy; RESP: result offered.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   last;       // previous winner, search starts above it
    logic [IDW-1:0]   winner;     // round-robin choice for this cycle
    logic             found;      // at least one requester is valid
    logic             rsp_fire;   // response handshake this cycle
    logic             grant;      // a request is accepted this cycle
    logic [N_REQ-1:0] ready;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_sum;
    logic [15:0]      op_cnt;
    logic [W-1:0]     req_a [N_REQ];
    logic [W-1:0]     req_b [N_REQ];

    // Unpack the flat operand buses into per-requester words.
    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign req_a[k] = i_req_a[k*W +: W];
        assign req_b[k] = i_req_b[k*W +: W];
    end

    // Round-robin search: first valid requester at or after last+1, wrapping.
    always_comb begin
        logic [IDW-1:0] cand;
        // NOTE: every variable written here gets a value before any
        // condition, so no path leaves it unassigned and no latch is inferred.
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = IDW'((int'(last) + off) % N_REQ);
            if (!found && i_req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Grant is possible from IDLE, or from RESP in the cycle the result is
    // consumed; it is suppressed while reset is held low.
    assign rsp_fire = (state == RESP) && i_rsp_ready;
    assign grant    = i_rst_n && found && ((state == IDLE) || rsp_fire);

    // One-hot accept strobe for the chosen requester.
    always_comb begin
        ready = '0;
        if (grant) begin
            ready[winner] = 1'b1;
        end
    end

    // Next-state logic for the IDLE -> EXEC -> RESP cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_fire) begin
                    state_next = grant ? EXEC : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, round-robin pointer, operand/result registers and op counter.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!i_rst_n) begin
            state   <= IDLE;
            last    <= IDW'(N_REQ - 1);
            add_a   <= '0;
            add_b   <= '0;
            rsp_id  <= '0;
            rsp_sum <= '0;
            op_cnt  <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                last   <= winner;
                rsp_id <= winner;
                add_a  <= req_a[winner];
                add_b  <= req_b[winner];
            end
            if (state == EXEC) begin
                rsp_sum <= i_add_sum;
            end
            if (rsp_fire && (op_cnt != CNT_MAX)) begin
                op_cnt <= op_cnt + 16'd1;
            end
        end
    end

    assign o_req_ready = ready;
    assign o_add_a     = add_a;
    assign o_add_b     = add_b;
    assign o_rsp_valid = (state == RESP);
    assign o_rsp_id    = rsp_id;
    assign o_rsp_sum   = rsp_sum;
    assign o_op_cnt    = op_cnt;

endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed stimulus with a transaction-level model of the
// scheduler (one op in flight, fixed two-cycle result latency, round-robin
// winner, saturating counter) compared against the DUT every cycle.
module tb_adder_share_arb;

    localparam int N_REQ = 4;
    localparam int W     = 32;
    localparam int IDW   = 2;
    localparam int BW    = N_REQ * W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_REQ-1:0] req_valid;
    logic [BW-1:0]    req_a;
    logic [BW-1:0]    req_b;
    logic [N_REQ-1:0] req_ready;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic [W-1:0]     add_sum;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_sum;
    logic             rsp_ready;
    logic [15:0]      op_cnt;

    always #5 clk = ~clk;

    // The shared adder lives outside the block.
    assign add_sum = add_a + add_b;

    adder_share_arb #(.N_REQ(N_REQ), .W(W), .IDW(IDW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_req_ready (req_ready),
        .o_add_a     (add_a),
        .o_add_b     (add_b),
        .i_add_sum   (add_sum),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_sum   (rsp_sum),
        .i_rsp_ready (rsp_ready),
        .o_op_cnt    (op_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Model state
    bit             m_init = 1'b0;
    int             m_cyc  = 0;
    bit             m_busy = 1'b0;
    int             m_vat  = 0;
    int             m_last = N_REQ - 1;
    logic [W-1:0]   m_a, m_b, m_sum;
    logic [IDW-1:0] m_id;
    logic [15:0]    m_cnt = '0;

    // Snapshot of DUT outputs from the last stepped cycle
    logic [N_REQ-1:0] s_ready;
    logic             s_valid;
    logic [IDW-1:0]   s_id;
    logic [W-1:0]     s_sum;
    logic [W-1:0]     s_add_a;
    logic [W-1:0]     s_add_b;
    logic [15:0]      s_cnt;

    // Per-requester pending operands and the observed grant log
    logic [W-1:0] qa [N_REQ][$];
    logic [W-1:0] qb [N_REQ][$];
    int g_id[$];
    int g_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
        end
    endtask

    // Present each requester's oldest pending op.
    task automatic drive();
        logic [BW-1:0]    a_bus;
        logic [BW-1:0]    b_bus;
        logic [N_REQ-1:0] v;
        a_bus = '0;
        b_bus = '0;
        v     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (qa[k].size() > 0) begin
                v     = v | (N_REQ'(1) << k);
                a_bus = a_bus | (BW'(qa[k][0]) << (k * W));
                b_bus = b_bus | (BW'(qb[k][0]) << (k * W));
            end
        end
        req_valid = v;
        req_a     = a_bus;
        req_b     = b_bus;
    endtask

    // Compare this cycle against the model, then advance the model one edge.
    task automatic step();
        bit               e_valid;
        bit               e_grant;
        logic [N_REQ-1:0] e_ready;
        int               w;
        int               k;
        int               gcyc;
        #2;
        e_valid = m_busy && (m_cyc >= m_vat);
        w = -1;
        for (int i = 1; i <= N_REQ; i++) begin
            k = (m_last + i) % N_REQ;
            if (w < 0 && (((req_valid >> k) & 1) != 0)) w = k;
        end
        e_grant = rst_n && (w >= 0) && (!m_busy || (e_valid && rsp_ready));
        e_ready = e_grant ? (N_REQ'(1) << w) : '0;

        s_ready = req_ready;
        s_valid = rsp_valid;
        s_id    = rsp_id;
        s_sum   = rsp_sum;
        s_add_a = add_a;
        s_add_b = add_b;
        s_cnt   = op_cnt;

        check("req_ready", s_ready, e_ready);
        if (m_init) begin
            check("rsp_valid", s_valid, e_valid);
            check("op_cnt", s_cnt, m_cnt);
            if (e_valid) begin
                check("rsp_id", s_id, m_id);
                check("rsp_sum", s_sum, m_sum);
            end
            if (m_busy && !e_valid) begin
                check("add_a", s_add_a, m_a);
                check("add_b", s_add_b, m_b);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (((s_ready >> j) & 1) != 0) begin
                g_id.push_back(j);
                g_cyc.push_back(m_cyc);
            end
        end

        @(posedge clk);
        gcyc = m_cyc;
        m_cyc++;
        if (!rst_n) begin
            m_init = 1'b1;
            m_busy = 1'b0;
            m_last = N_REQ - 1;
            m_cnt  = '0;
            m_a    = '0;
            m_b    = '0;
        end else begin
            if (e_valid && rsp_ready) begin
                m_busy = 1'b0;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            if (e_grant) begin
                m_busy = 1'b1;
                m_vat  = gcyc + 2;
                m_last = w;
                m_id   = IDW'(w);
                m_a    = W'(req_a >> (w * W));
                m_b    = W'(req_b >> (w * W));
                m_sum  = m_a + m_b;
            end
        end
        @(negedge clk);
    endtask

    // Requester side: drop the accepted op after its ready pulse.
    task automatic pop();
        for (int k = 0; k < N_REQ; k++) begin
            if ((((s_ready >> k) & 1) != 0) && qa[k].size() > 0) begin
                void'(qa[k].pop_front());
                void'(qb[k].pop_front());
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            step();
            pop();
        end
    endtask

    task automatic wait_valid(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            run(1);
            seen = s_valid;
        end
        if (!seen) check("wait rsp_valid timeout", 64'd0, 64'd1);
    endtask

    task automatic push(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        qa[k].push_back(a);
        qb[k].push_back(b);
    endtask

    initial begin
        int exp_order [6];
        exp_order = '{0, 1, 2, 3, 0, 1};
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        @(negedge clk);

        // Reset state
        run(2);
        check("reset rsp_valid", s_valid, 0);
        check("reset op_cnt", s_cnt, 0);
        check("reset add_a", s_add_a, 0);
        check("reset add_b", s_add_b, 0);
        check("reset rsp_id", s_id, 0);
        check("reset rsp_sum", s_sum, 0);
        rst_n = 1'b1;
        run(1);
        check("idle no grant", s_ready, 0);

        // Single op 5+7 from requester 0
        rsp_ready = 1'b1;
        push(0, 32'd5, 32'd7);
        run(1);
        check("single grant", s_ready, 4'b0001);
        run(1);
        check("single exec not valid", s_valid, 0);
        check("single exec add_a", s_add_a, 5);
        run(1);
        check("single rsp_valid", s_valid, 1);
        check("single rsp_id", s_id, 0);
        check("single rsp_sum", s_sum, 12);
        run(1);
        check("single op_cnt", s_cnt, 1);

        // Wraparound sum
        push(0, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_valid(8);
        check("wrap rsp_sum", s_sum, 32'h0000_0001);
        run(1);

        // Fairness after reset: all four requesters continuously valid
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        g_id.delete();
        g_cyc.delete();
        for (int k = 0; k < N_REQ; k++) begin
            push(k, 32'h100 * k + 1, 32'd100 + k);
            push(k, 32'h100 * k + 2, 32'd200 + k);
        end
        run(18);
        check("fair grant count", g_id.size() >= 6, 1);
        for (int i = 0; i < 6; i++) begin
            if (i < g_id.size()) begin
                check($sformatf("fair order %0d", i), g_id[i], exp_order[i]);
                if (i > 0) check($sformatf("fair gap %0d", i), g_cyc[i] - g_cyc[i-1], 2);
            end
        end
        check("fair op_cnt", s_cnt, 8);

        // Backpressure with requester 1 pending
        rsp_ready = 1'b0;
        push(0, 32'd10, 32'd20);
        wait_valid(8);
        push(1, 32'd3, 32'd4);
        for (int i = 0; i < 10; i++) begin
            run(1);
            check("bp no grant", s_ready, 0);
            check("bp sum held", s_sum, 30);
        end
        rsp_ready = 1'b1;
        run(1);
        check("bp release grant", s_ready, 4'b0010);
        check("bp release valid", s_valid, 1);
        wait_valid(4);
        check("bp req1 id", s_id, 1);
        check("bp req1 sum", s_sum, 7);
        run(1);

        // Reset during EXEC drops the op; requester 0 wins next
        push(2, 32'd1, 32'd1);
        run(1);
        check("midrst grant 2", s_ready, 4'b0100);
        rst_n = 1'b0;
        push(0, 32'd9, 32'd9);
        push(3, 32'd2, 32'd2);
        run(1);
        check("midrst ready low", s_ready, 0);
        rst_n = 1'b1;
        run(1);
        check("midrst rsp_valid", s_valid, 0);
        check("midrst op_cnt", s_cnt, 0);
        check("midrst add_a", s_add_a, 0);
        check("midrst grant 0", s_ready, 4'b0001);
        run(5);
        check("midrst drained op_cnt", s_cnt, 2);

        // Counter saturation
        force dut.op_cnt = 16'hFFFE;
        m_cnt = 16'hFFFE;
        run(1);
        release dut.op_cnt;
        run(1);
        check("sat preload", s_cnt, 16'hFFFE);
        push(1, 32'd1, 32'd2);
        push(1, 32'd3, 32'd4);
        push(1, 32'd5, 32'd6);
        run(8);
        check("sat op_cnt", s_cnt, 16'hFFFF);
        run(2);
        check("sat op_cnt held", s_cnt, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
